parity_frame_ctrl: RTL and testbench



---
 rtl/parity_frame_pkg.sv | 21 ++
 rtl/parity_acc.sv | 18 +
 rtl/parity_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_parity_frame_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity frame controller.
// Optional start/stop framing is enabled by defining PARITY_FRAME_START_STOP_EN.
package parity_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    START,
    STOP
  } state_t;

  localparam bit EVEN = 1'b0;
  localparam bit ODD  = 1'b1;

  // Bit counter must be able to hold DATA_W itself.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/parity_acc.sv
// 1-bit serial parity accumulator: XOR-toggles on every enabled bit.
module parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic par
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clr) par <= 1'b0;
    else if (en)      par <= par ^ bit_in;
  end

endmodule

// File: rtl/parity_frame_ctrl.sv
// Serializes one parallel word per frame LSB-first and appends a parity bit.
// Define PARITY_FRAME_START_STOP_EN to wrap each frame in a 0 start and 1 stop bit.
module parity_frame_ctrl
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_valid,
  output logic              tx_bit,
  output logic              tx_last,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              idle_ready;
  logic              load, shift, done_nxt;
  logic              acc_par;
  logic              tx_fire;

  assign in_ready = idle_ready & ~reset;
  assign load     = in_valid & in_ready;
  assign tx_fire  = tx_valid & tx_ready;

  parity_acc u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (load),
    .en     (shift),
    .bit_in (shreg[0]),
    .par    (acc_par)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    idle_ready = 1'b0;
    tx_valid   = 1'b0;
    tx_bit     = 1'b0;
    tx_last    = 1'b0;
    busy       = 1'b1;
    shift      = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        idle_ready = 1'b1;
        busy       = 1'b0;
`ifdef PARITY_FRAME_START_STOP_EN
        if (load) state_nxt = START;
`else
        if (load) state_nxt = SHIFT;
`endif
      end
`ifdef PARITY_FRAME_START_STOP_EN
      START: begin
        tx_valid = 1'b1;
        if (tx_fire) state_nxt = SHIFT;
      end
`endif
      SHIFT: begin
        tx_valid = 1'b1;
        tx_bit   = shreg[0];
        shift    = tx_fire;
        if (tx_fire && cnt == CNT_W'(DATA_W - 1)) state_nxt = PARITY;
      end
      PARITY: begin
        tx_valid = 1'b1;
        tx_bit   = acc_par ^ (ODD_PARITY == ODD);
`ifdef PARITY_FRAME_START_STOP_EN
        if (tx_fire) state_nxt = STOP;
`else
        tx_last  = 1'b1;
        if (tx_fire) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
`endif
      end
`ifdef PARITY_FRAME_START_STOP_EN
      STOP: begin
        tx_valid = 1'b1;
        tx_bit   = 1'b1;
        tx_last  = 1'b1;
        if (tx_fire) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= done_nxt;
      if (load) begin
        shreg <= in_data;
        cnt   <= '0;
      end else if (shift) begin
        shreg <= shreg >> 1;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Randomized self-checking bench for parity_frame_ctrl (even and odd instances).
// Honors PARITY_FRAME_START_STOP_EN when the build defines it.
module tb_parity_frame_ctrl;

  localparam int DW = 8;
`ifdef PARITY_FRAME_START_STOP_EN
  localparam int FL      = DW + 3;
  localparam int PAR_POS = DW + 1;
`else
  localparam int FL      = DW + 1;
  localparam int PAR_POS = DW;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          tx_ready;
  logic          in_ready, tx_valid, tx_bit, tx_last, busy, frame_done;
  logic          o_in_ready, o_tx_valid, o_tx_bit, o_tx_last, o_busy, o_frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_ctrl #(.DATA_W(DW), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done)
  );

  parity_frame_ctrl #(.DATA_W(DW), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(o_in_ready), .tx_valid(o_tx_valid), .tx_bit(o_tx_bit), .tx_last(o_tx_last),
    .tx_ready(tx_ready), .busy(o_busy), .frame_done(o_frame_done)
  );

  typedef struct {
    logic [FL-1:0] bits;
    logic [FL-1:0] obits;
    logic [FL-1:0] lasts;
    int            beats;
    int            stall_err;
    int            wait_cyc;
    int            lat;
    int            early_done;
    int            ready_busy;
  } frame_t;

  // Expected serial stream: the frame is built bit by bit from its definition.
  function automatic logic [FL-1:0] model(input logic [DW-1:0] w, input bit odd);
    bit            q[$];
    logic [FL-1:0] v;
    bit            p;
    p = bit'($countones(w) % 2) ^ odd;
`ifdef PARITY_FRAME_START_STOP_EN
    q.push_back(1'b0);
`endif
    for (int i = 0; i < DW; i++) q.push_back(w[i]);
    q.push_back(p);
`ifdef PARITY_FRAME_START_STOP_EN
    q.push_back(1'b1);
`endif
    v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  // Called and returns at a negedge. mode: 0 ready always, 1 pattern 1,0,0, 2 random.
  task automatic run_frame(input logic [DW-1:0] w, input int mode, input bit keep_valid,
                           input logic [DW-1:0] next_w, output frame_t r);
    logic held;
    bit   held_v;
    int   cyc;
    r.bits = '0; r.obits = '0; r.lasts = '0;
    r.beats = 0; r.stall_err = 0; r.wait_cyc = 0; r.lat = -1;
    r.early_done = 0; r.ready_busy = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && r.wait_cyc < 100) begin
      @(negedge clk);
      r.wait_cyc++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (keep_valid) in_data = next_w;
    else begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
    end
    held   = 1'b0;
    held_v = 1'b0;
    cyc    = 0;
    while (r.beats < FL && cyc < 400) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tx_valid && r.lat < 0) r.lat = cyc;
      if (in_ready || o_in_ready) r.ready_busy++;
      if (frame_done || o_frame_done) r.early_done++;
      if (tx_valid) begin
        if (held_v && tx_bit !== held) r.stall_err++;
        if (tx_ready) begin
          r.bits[r.beats]  = tx_bit;
          r.obits[r.beats] = o_tx_bit;
          r.lasts[r.beats] = tx_last;
          r.beats++;
          held_v = 1'b0;
        end else begin
          held   = tx_bit;
          held_v = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, tx_valid, tx_bit, tx_last, busy, frame_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {in_ready, tx_valid, tx_bit, tx_last, busy, frame_done});
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    checks++;
    if ({in_ready, o_in_ready, tx_valid, busy} !== 4'b1100) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 1100", {in_ready, o_in_ready, tx_valid, busy});
    end
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [DW-1:0] w, input logic exp_par);
    frame_t r;
    run_frame(w, 0, 1'b0, '0, r);
    checks++;
    if (r.bits !== model(w, 1'b0) || r.beats != FL) begin
      errors++;
      $display("FAIL basic_stream_%h: got %b (%0d beats) expected %b (%0d beats)",
               w, r.bits, r.beats, model(w, 1'b0), FL);
    end
    checks++;
    if (r.bits[PAR_POS] !== exp_par || r.obits[PAR_POS] !== ~exp_par) begin
      errors++;
      $display("FAIL basic_parity_%h: got even=%b odd=%b expected even=%b odd=%b",
               w, r.bits[PAR_POS], r.obits[PAR_POS], exp_par, ~exp_par);
    end
    checks++;
    if (r.lasts !== (FL'(1) << (FL - 1))) begin
      errors++;
      $display("FAIL basic_last_%h: got %b expected %b", w, r.lasts, FL'(1) << (FL - 1));
    end
    checks++;
    if (r.lat != 0 || r.early_done != 0 || r.ready_busy != 0) begin
      errors++;
      $display("FAIL basic_timing_%h: got lat=%0d early_done=%0d ready_busy=%0d expected 0,0,0",
               w, r.lat, r.early_done, r.ready_busy);
    end
    checks++;
    if ({frame_done, o_frame_done, in_ready, busy, tx_valid} !== 5'b11100) begin
      errors++;
      $display("FAIL basic_done_%h: got %b expected 11100", w,
               {frame_done, o_frame_done, in_ready, busy, tx_valid});
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse_%h: got %b expected 0", w, frame_done);
    end
  endtask

  task automatic test_backpressure;
    frame_t r;
    run_frame(8'h3C, 1, 1'b0, '0, r);
    checks++;
    if (r.bits !== model(8'h3C, 1'b0) || r.obits !== model(8'h3C, 1'b1)) begin
      errors++;
      $display("FAIL bp_stream: got %b/%b expected %b/%b", r.bits, r.obits,
               model(8'h3C, 1'b0), model(8'h3C, 1'b1));
    end
    checks++;
    if (r.beats != FL || r.stall_err != 0) begin
      errors++;
      $display("FAIL bp_beats: got beats=%0d stall_err=%0d expected beats=%0d stall_err=0",
               r.beats, r.stall_err, FL);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: got %b expected 1", frame_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    frame_t r;
    int     n = 0;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_active: got %b expected 11", {tx_valid, busy});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_valid, busy, in_ready, frame_done, o_tx_valid} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_abort: got %b expected 00000",
               {tx_valid, busy, in_ready, frame_done, o_tx_valid});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    run_frame(8'hFF, 0, 1'b0, '0, r);
    checks++;
    if (r.bits !== model(8'hFF, 1'b0) || r.bits[PAR_POS] !== 1'b0 || r.beats != FL) begin
      errors++;
      $display("FAIL midrst_ff: got %b (%0d beats) expected %b", r.bits, r.beats, model(8'hFF, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    frame_t r1, r2;
    run_frame(8'h01, 0, 1'b1, 8'h80, r1);
    checks++;
    if ({frame_done, in_ready} !== 2'b11 || r1.ready_busy != 0) begin
      errors++;
      $display("FAIL b2b_gap: got done,ready=%b ready_busy=%0d expected 11, 0",
               {frame_done, in_ready}, r1.ready_busy);
    end
    run_frame(8'h80, 0, 1'b0, '0, r2);
    checks++;
    if (r2.wait_cyc != 0) begin
      errors++;
      $display("FAIL b2b_accept: got wait=%0d expected 0", r2.wait_cyc);
    end
    checks++;
    if (r1.bits !== model(8'h01, 1'b0) || r2.bits !== model(8'h80, 1'b0) ||
        r1.bits[PAR_POS] !== 1'b1 || r2.bits[PAR_POS] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_streams: got %b,%b expected %b,%b", r1.bits, r2.bits,
               model(8'h01, 1'b0), model(8'h80, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    frame_t        r;
    logic [DW-1:0] w;
    for (int k = 0; k < 20; k++) begin
      w = DW'($urandom);
      run_frame(w, 2, 1'b0, '0, r);
      checks++;
      if (r.bits !== model(w, 1'b0) || r.obits !== model(w, 1'b1) || r.beats != FL ||
          r.stall_err != 0 || r.early_done != 0) begin
        errors++;
        $display("FAIL rand_%0d_%h: got %b/%b beats=%0d stall=%0d expected %b/%b beats=%0d",
                 k, w, r.bits, r.obits, r.beats, r.stall_err, model(w, 1'b0), model(w, 1'b1), FL);
      end
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tx_ready = 1'b0;
    test_reset();
    test_basic(8'hA5, 1'b0);
    test_basic(8'h07, 1'b1);
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
